// File: rtl/pipe_reg.sv
// pipe_reg -- one-stage valid/ready pipeline register with optional skid entry.
//
// Purpose
//   Registers a valid/ready stream with a latency of exactly one cycle. The
//   head register drives out_data directly. When the macro PIPE_REG_SKID_EN is
//   defined, a one-entry skid register sits behind the head. This keeps
//   in_ready a registered signal (skid empty) and lets a word be accepted in
//   the same cycle that the downstream stalls. When the macro is undefined,
//   there is no skid entry and in_ready is formed combinationally from
//   out_ready.
//
// Parameters
//   WIDTH        data path width in bits (1..64)
//   RESET_VALUE  value loaded into the data registers on reset and at power-up
//
// Ports
//   clk        in   rising-edge clock
//   nrst       in   synchronous active-low reset (priority over flush)
//   flush      in   synchronous discard of every held entry
//   in_valid   in   upstream presents in_data
//   in_ready   out  block accepts a word this cycle
//   in_data    in   upstream payload [WIDTH]
//   out_valid  out  out_data holds a live entry
//   out_ready  in   downstream consumes out_data this cycle
//   out_data   out  head payload [WIDTH], straight from the head register
//   count      out  number of held entries (0..2)
//
// Configuration macro: PIPE_REG_SKID_EN (undefined = no skid register)

module pipe_reg #(
  parameter int unsigned      WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  // Declaration initialisers give a power-up state that matches the reset
  // state. This holds in simulation and on FPGA targets, so no reset pulse is
  // needed before the first transfer.
  logic             head_valid_reg = 1'b0;
  logic [WIDTH-1:0] head_data_reg  = RESET_VALUE;
  logic             head_valid_next;
  logic [WIDTH-1:0] head_data_next;

  logic in_fire;
  logic out_fire;

  assign in_fire   = in_valid & in_ready;
  assign out_fire  = head_valid_reg & out_ready;
  assign out_valid = head_valid_reg;
  assign out_data  = head_data_reg;

`ifdef PIPE_REG_SKID_EN

  logic             skid_valid_reg = 1'b0;
  logic [WIDTH-1:0] skid_data_reg  = RESET_VALUE;
  logic             skid_valid_next;
  logic [WIDTH-1:0] skid_data_next;

  // in_ready depends only on register state (the skid is empty). The nrst
  // term forces it low while reset is asserted.
  assign in_ready = nrst & ~skid_valid_reg;
  assign count    = {1'b0, head_valid_reg} + {1'b0, skid_valid_reg};

  always_comb begin
    head_valid_next = head_valid_reg;
    head_data_next  = head_data_reg;
    skid_valid_next = skid_valid_reg;
    skid_data_next  = skid_data_reg;
    if (flush) begin
      // Only occupancy is cleared. The data registers keep their contents,
      // which become dead.
      head_valid_next = 1'b0;
      skid_valid_next = 1'b0;
    end else if (out_fire || !head_valid_reg) begin
      // The head register is free this cycle. A waiting skid word has
      // priority over new input. in_ready is low whenever the skid is full,
      // so the two sources never compete.
      if (skid_valid_reg) begin
        head_valid_next = 1'b1;
        head_data_next  = skid_data_reg;
        skid_valid_next = 1'b0;
      end else begin
        head_valid_next = in_fire;
        if (in_fire) begin
          head_data_next = in_data;
        end
      end
    end else if (in_fire) begin
      // The head is held and stalled, so the accepted word goes to the skid.
      skid_valid_next = 1'b1;
      skid_data_next  = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      head_valid_reg <= 1'b0;
      head_data_reg  <= RESET_VALUE;
      skid_valid_reg <= 1'b0;
      skid_data_reg  <= RESET_VALUE;
    end else begin
      head_valid_reg <= head_valid_next;
      head_data_reg  <= head_data_next;
      skid_valid_reg <= skid_valid_next;
      skid_data_reg  <= skid_data_next;
    end
  end

`else

  // Without a skid entry, a word can be accepted only if the head is empty
  // or is being drained this very cycle.
  assign in_ready = nrst & (~head_valid_reg | out_ready);
  assign count    = {1'b0, head_valid_reg};

  always_comb begin
    head_valid_next = head_valid_reg;
    head_data_next  = head_data_reg;
    if (flush) begin
      head_valid_next = 1'b0;
    end else if (out_fire || !head_valid_reg) begin
      head_valid_next = in_fire;
      if (in_fire) begin
        head_data_next = in_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      head_valid_reg <= 1'b0;
      head_data_reg  <= RESET_VALUE;
    end else begin
      head_valid_reg <= head_valid_next;
      head_data_reg  <= head_data_next;
    end
  end

`endif

endmodule

// File: tb/tb_pipe_reg.sv
// Testbench for pipe_reg: power-up check, directed vector table, and
// randomized stress against a queue-based reference model.
// This file follows whichever setting of PIPE_REG_SKID_EN the design uses.

module tb_pipe_reg;

  localparam int unsigned W  = 32;
  localparam logic [31:0] RV = 32'hA5A5A5A5;
`ifdef PIPE_REG_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic        clk       = 1'b0;
  logic        nrst      = 1'b1;
  logic        flush     = 1'b0;
  logic        in_valid  = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_data   = '0;
  wire         in_ready;
  wire         out_valid;
  wire  [31:0] out_data;
  wire  [1:0]  count;

  pipe_reg #(.WIDTH(W), .RESET_VALUE(RV)) dut (
    .clk      (clk),
    .nrst     (nrst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .count    (count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, got, exp);
    end
  endtask

  // Each record spans one clock cycle. The inputs are applied after the
  // falling edge. in_ready is checked before the next rising edge. The other
  // outputs are checked just after that rising edge.
  typedef struct {
    logic        nrst;
    logic        flush;
    logic        iv;
    logic [31:0] id;
    logic        ordy;
    logic        e_irdy;
    logic        e_ov;
    logic [31:0] e_od;
    logic [1:0]  e_cnt;
    logic        chk_d;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic n, input logic f, input logic iv, input logic [31:0] id,
                              input logic ordy, input logic e_irdy, input logic e_ov,
                              input logic [31:0] e_od, input logic [1:0] e_cnt, input logic chk_d);
    vec_t v;
    v.nrst = n; v.flush = f; v.iv = iv; v.id = id; v.ordy = ordy;
    v.e_irdy = e_irdy; v.e_ov = e_ov; v.e_od = e_od; v.e_cnt = e_cnt; v.chk_d = chk_d;
    return v;
  endfunction

  // Reference model: the held entries in order, oldest at index 0.
  logic [31:0] mq[$];
  logic        exp_rdy;
  logic        was_reset;

  initial begin
    // Power-up state, sampled before any clock edge and without a reset pulse.
    #1;
    check("powerup out_valid", {31'd0, out_valid}, 32'd0);
    check("powerup count", {30'd0, count}, 32'd0);
    check("powerup out_data", out_data, RV);
    check("powerup in_ready", {31'd0, in_ready}, 32'd1);

    // Streaming with out_ready=1.
    tbl.push_back(mk(1, 0, 1, 32'h11111111, 1, 1, 1, 32'h11111111, 2'd1, 1));
    tbl.push_back(mk(1, 0, 1, 32'h22222222, 1, 1, 1, 32'h22222222, 2'd1, 1));
    tbl.push_back(mk(1, 0, 1, 32'h33333333, 1, 1, 1, 32'h33333333, 2'd1, 1));
    tbl.push_back(mk(1, 0, 0, 32'h0,        1, 1, 0, 32'h0,        2'd0, 0));
    // Stall on 0xDEADBEEF for five cycles, then offer 0xCAFEF00D.
    tbl.push_back(mk(1, 0, 1, 32'hDEADBEEF, 0, 1, 1, 32'hDEADBEEF, 2'd1, 1));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(1, 0, 0, 32'h0, 0, SKID, 1, 32'hDEADBEEF, 2'd1, 1));
    tbl.push_back(mk(1, 0, 1, 32'hCAFEF00D, 0, SKID, 1, 32'hDEADBEEF, SKID ? 2'd2 : 2'd1, 1));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 0,    1, 32'hDEADBEEF, SKID ? 2'd2 : 2'd1, 1));
    // Drain.
    tbl.push_back(mk(1, 0, 0, 32'h0, 1, !SKID, SKID, 32'hCAFEF00D, SKID ? 2'd1 : 2'd0, SKID));
    tbl.push_back(mk(1, 0, 0, 32'h0, 1, 1,     0,    32'h0,        2'd0,              0));
    // Fill, then flush with 0x5 offered. The data registers stay unchanged.
    tbl.push_back(mk(1, 0, 1, 32'h12345678, 0, 1,     1, 32'h12345678, 2'd1, 1));
    tbl.push_back(mk(1, 0, 1, 32'h9ABCDEF0, 0, SKID,  1, 32'h12345678, SKID ? 2'd2 : 2'd1, 1));
    tbl.push_back(mk(1, 1, 1, 32'h00000005, 1, !SKID, 0, 32'h12345678, 2'd0, 1));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 1,     0, 32'h12345678, 2'd0, 1));
    // Fill, then reset mid-stream.
    tbl.push_back(mk(1, 0, 1, 32'h0BADF00D, 0, 1,    1, 32'h0BADF00D, 2'd1, 1));
    tbl.push_back(mk(1, 0, 1, 32'hFEEDFACE, 0, SKID, 1, 32'h0BADF00D, SKID ? 2'd2 : 2'd1, 1));
    tbl.push_back(mk(0, 0, 1, 32'h77777777, 1, 0,    0, RV,           2'd0, 1));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 1,    0, RV,           2'd0, 1));
    tbl.push_back(mk(1, 0, 1, 32'h44444444, 1, 1,    1, 32'h44444444, 2'd1, 1));
    tbl.push_back(mk(1, 0, 0, 32'h0,        1, 1,    0, 32'h0,        2'd0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      nrst = tbl[i].nrst; flush = tbl[i].flush; in_valid = tbl[i].iv;
      in_data = tbl[i].id; out_ready = tbl[i].ordy;
      #1;
      check($sformatf("row%0d in_ready", i), {31'd0, in_ready}, {31'd0, tbl[i].e_irdy});
      @(posedge clk);
      #1;
      check($sformatf("row%0d out_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].e_ov});
      check($sformatf("row%0d count", i), {30'd0, count}, {30'd0, tbl[i].e_cnt});
      if (tbl[i].chk_d)
        check($sformatf("row%0d out_data", i), out_data, tbl[i].e_od);
    end

    // Randomized stress. The bench ends the table with the block empty.
    mq.delete();
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      nrst      = ($urandom_range(0, 99) != 0);
      flush     = ($urandom_range(0, 63) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 1));
      in_data   = $urandom;
      if (SKID) exp_rdy = nrst && (mq.size() < 2);
      else      exp_rdy = nrst && (mq.size() == 0 || out_ready);
      #1;
      check($sformatf("rnd%0d in_ready", c), {31'd0, in_ready}, {31'd0, exp_rdy});
      was_reset = !nrst;
      if (!nrst || flush) begin
        mq.delete();
      end else begin
        if (mq.size() > 0 && out_ready) void'(mq.pop_front());
        if (in_valid && exp_rdy) mq.push_back(in_data);
      end
      @(posedge clk);
      #1;
      check($sformatf("rnd%0d out_valid", c), {31'd0, out_valid}, {31'd0, (mq.size() > 0)});
      check($sformatf("rnd%0d count", c), {30'd0, count}, mq.size());
      if (mq.size() > 0)
        check($sformatf("rnd%0d out_data", c), out_data, mq[0]);
      else if (was_reset)
        check($sformatf("rnd%0d reset out_data", c), out_data, RV);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
